// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execute sequencer: funct codes, FSM states,
// internal ALU operations, and the instruction decoder.
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // addu/subu are distinct ops so the ALU itself suppresses overflow for them.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    illegal;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.alu_op  = ALU_ADD;
        d.illegal = 1'b0;
        if (opcode != OP_RTYPE) begin
            d.illegal = 1'b1;
        end else begin
            case (funct)
                F_ADD:   d.alu_op = ALU_ADD;
                F_ADDU:  d.alu_op = ALU_ADDU;
                F_SUB:   d.alu_op = ALU_SUB;
                F_SUBU:  d.alu_op = ALU_SUBU;
                F_AND:   d.alu_op = ALU_AND;
                F_OR:    d.alu_op = ALU_OR;
                F_XOR:   d.alu_op = ALU_XOR;
                F_NOR:   d.alu_op = ALU_NOR;
                F_SLT:   d.alu_op = ALU_SLT;
                F_SLTU:  d.alu_op = ALU_SLTU;
                F_SLL:   d.alu_op = ALU_SLL;
                F_SRL:   d.alu_op = ALU_SRL;
                F_SRA:   d.alu_op = ALU_SRA;
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/rtype_exec_ctrl_alu32.sv
// Combinational ALU for the R-type sequencer: arithmetic, logic, compare, shifts.
// Shifts operate on b by shamt; overflow is reported only for signed add/sub.
module alu32
    import rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  alu_op_t           alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              of
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = sum;
                of     = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result = diff;
                of     = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            default:  result = '0;
        endcase
    end

    assign zf = (result == '0);

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Four-cycle R-type sequencer in front of the register file: IDLE -> READ -> EXEC -> WB.
// Accepts one instruction per 4 cycles; all outputs are registered.
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [31:0]       inst,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic              done,
    output logic              zf,
    output logic              of,
    output logic              illegal
);

    state_t            state_q;
    logic [31:0]       inst_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              inst_ready_q;
    logic [ADDR_W-1:0] r_addr_a_q, r_addr_b_q, w_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic              write_reg_q, done_q, zf_q, of_q, illegal_q;

    dec_t              dec_d;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_zf_d, alu_of_d, of_d;

    assign dec_d = decode(inst_q[31:26], inst_q[5:0]);
    assign of_d  = alu_of_d && !dec_d.illegal;

    alu32 #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .shamt  (inst_q[10:6]),
        .alu_op (dec_d.alu_op),
        .result (alu_res_d),
        .zf     (alu_zf_d),
        .of     (alu_of_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            inst_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            inst_ready_q <= 1'b1;
            r_addr_a_q   <= '0;
            r_addr_b_q   <= '0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            write_reg_q  <= 1'b0;
            done_q       <= 1'b0;
            zf_q         <= 1'b0;
            of_q         <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_valid && inst_ready_q) begin
                        inst_q       <= inst;
                        r_addr_a_q   <= inst[25:21];
                        r_addr_b_q   <= inst[20:16];
                        inst_ready_q <= 1'b0;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    a_q     <= R_Data_A;
                    b_q     <= R_Data_B;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    w_addr_q    <= inst_q[15:11];
                    w_data_q    <= alu_res_d;
                    zf_q        <= alu_zf_d;
                    of_q        <= of_d;
                    illegal_q   <= dec_d.illegal;
                    // rd==0 still retires, it just never reaches the register file
                    write_reg_q <= (inst_q[15:11] != 5'd0) && !of_d && !dec_d.illegal;
                    done_q      <= 1'b1;
                    state_q     <= S_WB;
                end
                S_WB: begin
                    write_reg_q  <= 1'b0;
                    done_q       <= 1'b0;
                    inst_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    write_reg_q  <= 1'b0;
                    done_q       <= 1'b0;
                    inst_ready_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready = inst_ready_q;
    assign R_Addr_A   = r_addr_a_q;
    assign R_Addr_B   = r_addr_b_q;
    assign W_Addr     = w_addr_q;
    assign W_Data     = w_data_q;
    assign Write_Reg  = write_reg_q;
    assign done       = done_q;
    assign zf         = zf_q;
    assign of         = of_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
// Directed bench: rtype_exec_ctrl driving a behavioural 32x32 register file.
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
    logic [31:0] R_Data_A, R_Data_B, W_Data;
    logic        Write_Reg, done, zf, of, illegal;

    logic [31:0] rf [32];
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [31:0] tb_wd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rtype_exec_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .R_Data_A   (R_Data_A),
        .R_Data_B   (R_Data_B),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .done       (done),
        .zf         (zf),
        .of         (of),
        .illegal    (illegal)
    );

    assign R_Data_A = (R_Addr_A == 5'd0) ? 32'd0 : rf[R_Addr_A];
    assign R_Data_B = (R_Addr_B == 5'd0) ? 32'd0 : rf[R_Addr_B];

    always @(posedge clk) begin
        if (tb_we) rf[tb_wa] <= tb_wd;
        else if (Write_Reg && W_Addr != 5'd0) rf[W_Addr] <= W_Data;
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Issue one word; lat = edges from accept edge to the cycle where done is seen, -1 on timeout.
    task automatic exec_inst(input logic [31:0] w, output int lat);
        int n = 0;
        @(negedge clk);
        while (!inst_ready && n < 8) begin @(negedge clk); n++; end
        inst = w; inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; inst_valid = 1'b0; inst = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({inst_ready, R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, done, zf, of, illegal} !==
            {1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b ra=%0d rb=%0d wa=%0d wd=%h wr=%b done=%b zf=%b of=%b ill=%b, want ready=1 rest 0",
                     inst_ready, R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, done, zf, of, illegal);
        end
        @(negedge clk); reset = 1'b0;
        for (int r = 0; r < 32; r++) preload(r[4:0], 32'd0);
    endtask

    task automatic test_add;
        int lat;
        preload(5'd1, 32'h11111111);
        preload(5'd3, 32'h22222222);
        exec_inst(32'h00233820, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d edges, want 2", lat); end
        n_checks++;
        if ({Write_Reg, W_Addr, W_Data, zf, of, illegal} !== {1'b1, 5'd7, 32'h33333333, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_wb: wr=%b wa=%0d wd=%h zf=%b of=%b ill=%b, want 1 7 33333333 0 0 0",
                     Write_Reg, W_Addr, W_Data, zf, of, illegal);
        end
        step;
        n_checks++;
        if ({Write_Reg, done, inst_ready} !== 3'b001) begin
            n_fail++; $display("FAIL add_after_wb: wr=%b done=%b ready=%b, want 0 0 1", Write_Reg, done, inst_ready);
        end
        n_checks++;
        if (rf[7] !== 32'h33333333) begin n_fail++; $display("FAIL add_reg7: got %h, want 33333333", rf[7]); end
    endtask

    task automatic test_sub_overflow;
        int lat;
        preload(5'd1, 32'h80000000);
        preload(5'd3, 32'h00000001);
        exec_inst(32'h00233822, lat);
        n_checks++;
        if ({lat == 2, of, Write_Reg, done} !== 4'b1101) begin
            n_fail++; $display("FAIL sub_of: lat=%0d of=%b wr=%b done=%b, want 2 1 0 1", lat, of, Write_Reg, done);
        end
        step; step;
        n_checks++;
        if (of !== 1'b1) begin n_fail++; $display("FAIL sub_of_held: of=%b, want 1", of); end
        n_checks++;
        if (rf[7] !== 32'h33333333) begin n_fail++; $display("FAIL sub_reg7_unchanged: got %h, want 33333333", rf[7]); end
        exec_inst(32'h00233823, lat);
        n_checks++;
        if ({of, Write_Reg, W_Data} !== {1'b0, 1'b1, 32'h7FFFFFFF}) begin
            n_fail++; $display("FAIL subu: of=%b wr=%b wd=%h, want 0 1 7fffffff", of, Write_Reg, W_Data);
        end
        step;
        n_checks++;
        if (rf[7] !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL subu_reg7: got %h, want 7fffffff", rf[7]); end
    endtask

    task automatic test_slt;
        int lat;
        preload(5'd1, 32'hFFFFFFFF);
        preload(5'd3, 32'h00000001);
        exec_inst(32'h0023382A, lat);
        step;
        n_checks++;
        if (rf[7] !== 32'h00000001) begin n_fail++; $display("FAIL slt: got %h, want 00000001", rf[7]); end
        exec_inst(32'h0023382B, lat);
        n_checks++;
        if ({zf, Write_Reg} !== 2'b11) begin n_fail++; $display("FAIL sltu_zf: zf=%b wr=%b, want 1 1", zf, Write_Reg); end
        step;
        n_checks++;
        if (rf[7] !== 32'h00000000) begin n_fail++; $display("FAIL sltu: got %h, want 00000000", rf[7]); end
    endtask

    task automatic test_shift;
        int lat;
        logic [31:0] words [3];
        logic [31:0] want  [3];
        preload(5'd3, 32'h80000000);
        words[0] = 32'h00033903; want[0] = 32'hF8000000;
        words[1] = 32'h00033902; want[1] = 32'h08000000;
        words[2] = 32'h00033900; want[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            exec_inst(words[i], lat);
            step;
            n_checks++;
            if (rf[7] !== want[i]) begin
                n_fail++; $display("FAIL shift_%0d: inst=%h got %h, want %h", i, words[i], rf[7], want[i]);
            end
        end
        preload(5'd3, 32'h80000001);
        exec_inst(32'h00033900, lat);
        step;
        n_checks++;
        if (rf[7] !== 32'h00000010) begin n_fail++; $display("FAIL sll: got %h, want 00000010", rf[7]); end
    endtask

    task automatic test_logic;
        int lat;
        logic [31:0] want [4];
        preload(5'd1, 32'hF0F0F0F0);
        preload(5'd3, 32'h0FF00FF0);
        want[0] = 32'h00F000F0; want[1] = 32'hFFF0FFF0;
        want[2] = 32'hFF00FF00; want[3] = 32'h000F000F;
        for (int i = 0; i < 4; i++) begin
            exec_inst(32'h00233824 + i, lat);
            step;
            n_checks++;
            if (rf[7] !== want[i]) begin
                n_fail++; $display("FAIL logic_%0d: got %h, want %h", i, rf[7], want[i]);
            end
        end
        exec_inst(32'h00213826, lat);
        n_checks++;
        if ({zf, W_Data} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL xor_self_zf: zf=%b wd=%h, want 1 0", zf, W_Data); end
        step;
    endtask

    task automatic test_rd_zero_illegal;
        int lat;
        exec_inst(32'h00230020, lat);
        n_checks++;
        if ({lat == 2, done, Write_Reg, illegal} !== 4'b1100) begin
            n_fail++; $display("FAIL rd_zero: lat=%0d done=%b wr=%b ill=%b, want 2 1 0 0", lat, done, Write_Reg, illegal);
        end
        step;
        preload(5'd7, 32'h5A5A5A5A);
        exec_inst(32'h8C230000, lat);
        n_checks++;
        if ({lat == 2, illegal, Write_Reg} !== 3'b110) begin
            n_fail++; $display("FAIL illegal_op: lat=%0d ill=%b wr=%b, want 2 1 0", lat, illegal, Write_Reg);
        end
        exec_inst(32'h0023383F, lat);
        n_checks++;
        if ({illegal, Write_Reg, of} !== 3'b100) begin
            n_fail++; $display("FAIL illegal_funct: ill=%b wr=%b of=%b, want 1 0 0", illegal, Write_Reg, of);
        end
        step;
        n_checks++;
        if (rf[7] !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL illegal_no_write: got %h, want 5a5a5a5a", rf[7]); end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1;
        preload(5'd1, 32'h00000005);
        preload(5'd3, 32'h0000000A);
        @(negedge clk);
        inst = 32'h00234020; inst_valid = 1'b1;
        @(posedge clk); #1;
        inst = 32'h00234825;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done && first < 0) first = i;
            else if (done) begin second = i; break; end
        end
        inst_valid = 1'b0;
        step;
        n_checks++;
        if (first !== 2 || second !== 6) begin
            n_fail++; $display("FAIL b2b_timing: done at %0d and %0d, want 2 and 6", first, second);
        end
        n_checks++;
        if ({rf[8], rf[9]} !== {32'h0000000F, 32'h0000000F}) begin
            n_fail++; $display("FAIL b2b_data: r8=%h r9=%h, want 0000000f 0000000f", rf[8], rf[9]);
        end
    endtask

    task automatic test_reset_mid_exec;
        int wr_seen = 0;
        preload(5'd1, 32'h11111111);
        preload(5'd3, 32'h22222222);
        preload(5'd7, 32'hCAFEF00D);
        @(negedge clk);
        inst = 32'h00233820; inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({inst_ready, R_Addr_A, R_Addr_B, W_Addr, W_Data, Write_Reg, done, zf, of, illegal} !==
            {1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_exec: ready=%b ra=%0d wa=%0d wd=%h wr=%b done=%b, want 1 0 0 0 0 0",
                     inst_ready, R_Addr_A, W_Addr, W_Data, Write_Reg, done);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (Write_Reg || done) wr_seen++;
        end
        n_checks++;
        if (wr_seen !== 0 || rf[7] !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL reset_no_wb: pulses=%0d r7=%h, want 0 cafef00d", wr_seen, rf[7]);
        end
    endtask

    task automatic test_reset_with_valid;
        @(negedge clk);
        reset = 1'b1; inst = 32'h00233820; inst_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; inst_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({inst_ready, R_Addr_A, R_Addr_B} !== {1'b1, 5'd0, 5'd0}) begin
            n_fail++; $display("FAIL reset_wins: ready=%b ra=%0d rb=%0d, want 1 0 0", inst_ready, R_Addr_A, R_Addr_B);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_overflow;
        test_slt;
        test_shift;
        test_logic;
        test_rd_zero_illegal;
        test_back_to_back;
        test_reset_mid_exec;
        test_reset_with_valid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
